// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX skid stage: ALU opcodes, operand selects,
// the buffered entry layout and the occupancy FSM encoding.
package id_ex_stage_pkg;

    localparam logic [5:0] ALU_NOP = 6'b000_000;
    localparam logic [5:0] ALU_ADD = 6'b000_001;
    localparam logic [5:0] ALU_SUB = 6'b000_010;
    localparam logic [5:0] ALU_AND = 6'b000_011;
    localparam logic [5:0] ALU_OR  = 6'b000_100;
    localparam logic [5:0] ALU_XOR = 6'b000_101;
    localparam logic [5:0] ALU_SLL = 6'b000_110;
    localparam logic [5:0] ALU_SRL = 6'b000_111;

    localparam logic [1:0] SEL_A_RS1 = 2'b00;
    localparam logic [1:0] SEL_A_PC  = 2'b01;
    localparam logic [1:0] SEL_A_PC4 = 2'b10;
    localparam logic [1:0] SEL_A_RSV = 2'b11;

    localparam logic SEL_B_RS2 = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    typedef struct packed {
        logic [5:0]  alu_op;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic [31:0] pc;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Wraps at 2^32 so a jump-and-link at the top of memory links to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and execute-side handshake bundle of the ID/EX stage.
// slave = the stage itself, master = whoever drives decode and consumes execute.
interface id_ex_stage_if;

    logic        in_valid_i;
    logic        in_ready_o;
    logic [5:0]  ALUop_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [4:0]  rd_addr_i;
    logic [1:0]  sel_a_i;
    logic        sel_b_i;

    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  ALUop_o;
    logic [31:0] operand_A_o;
    logic [31:0] operand_B_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] pc_o;

    modport slave (
        input  in_valid_i, ALUop_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
        input  rs1_addr_i, rs2_addr_i, rd_addr_i, sel_a_i, sel_b_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o, ALUop_o, operand_A_o, operand_B_o,
        output rd_addr_o, pc_o
    );

    modport master (
        output in_valid_i, ALUop_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
        output rs1_addr_i, rs2_addr_i, rd_addr_i, sel_a_i, sel_b_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o, ALUop_o, operand_A_o, operand_B_o,
        input  rd_addr_o, pc_o
    );

endinterface

// File: rtl/id_ex_operand_mux.sv
// Capture-side operand forwarding and A/B selection for the ID/EX stage.
// Writeback bypass is compiled in only when ID_EX_FORWARDING_EN is defined.
module id_ex_operand_mux
    import id_ex_stage_pkg::*;
(
    input  logic [5:0]  alu_op_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [1:0]  sel_a_i,
    input  logic        sel_b_i,
    input  logic        fwd_valid_i,
    input  logic [4:0]  fwd_rd_i,
    input  logic [31:0] fwd_data_i,
    output entry_t      entry_o
);

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

`ifdef ID_EX_FORWARDING_EN
    logic fwd_hit1;
    logic fwd_hit2;

    // x0 is hardwired to zero, so a writeback aimed at it never bypasses.
    assign fwd_hit1 = fwd_valid_i && (fwd_rd_i != 5'd0)
                      && (fwd_rd_i == rs1_addr_i);
    assign fwd_hit2 = fwd_valid_i && (fwd_rd_i != 5'd0)
                      && (fwd_rd_i == rs2_addr_i);
    assign rs1_val  = fwd_hit1 ? fwd_data_i : rs1_data_i;
    assign rs2_val  = fwd_hit2 ? fwd_data_i : rs2_data_i;
`else
    logic unused_fwd;

    assign rs1_val    = rs1_data_i;
    assign rs2_val    = rs2_data_i;
    assign unused_fwd = ^{fwd_valid_i, fwd_rd_i, fwd_data_i,
                          rs1_addr_i, rs2_addr_i};
`endif

    always_comb begin
        entry_o        = '0;
        entry_o.alu_op = alu_op_i;
        entry_o.rd     = rd_addr_i;
        entry_o.pc     = pc_i;
        unique case (sel_a_i)
            SEL_A_PC:  entry_o.op_a = pc_i;
            SEL_A_PC4: entry_o.op_a = pc_plus4(pc_i);
            default:   entry_o.op_a = rs1_val;
        endcase
        entry_o.op_b = (sel_b_i == SEL_B_IMM) ? imm_i : rs2_val;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register built as a 2-entry skid buffer with registered ready.
// Optional writeback bypass: define ID_EX_FORWARDING_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        fwd_valid_i,
    input  logic [4:0]  fwd_rd_i,
    input  logic [31:0] fwd_data_i,
    id_ex_stage_if.slave bus
);

    entry_t  entry_d;
    entry_t  buf_q [DEPTH];
    entry_t  head;
    state_e  state_q;
    logic    in_ready_q;
    logic    out_valid;
    logic    push;
    logic    pop;

    id_ex_operand_mux u_mux (
        .alu_op_i    (bus.ALUop_i),
        .pc_i        (bus.pc_i),
        .rs1_data_i  (bus.rs1_data_i),
        .rs2_data_i  (bus.rs2_data_i),
        .imm_i       (bus.imm_i),
        .rs1_addr_i  (bus.rs1_addr_i),
        .rs2_addr_i  (bus.rs2_addr_i),
        .rd_addr_i   (bus.rd_addr_i),
        .sel_a_i     (bus.sel_a_i),
        .sel_b_i     (bus.sel_b_i),
        .fwd_valid_i (fwd_valid_i),
        .fwd_rd_i    (fwd_rd_i),
        .fwd_data_i  (fwd_data_i),
        .entry_o     (entry_d)
    );

    assign out_valid = (state_q != EMPTY);
    assign push      = bus.in_valid_i && in_ready_q;
    assign pop       = out_valid && bus.out_ready_i;

    // Ready is a flop: it tracks next-state occupancy so out_ready_i
    // never reaches in_ready_o combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (flush_i) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (push) begin
                        buf_q[0] <= entry_d;
                        state_q  <= ONE;
                    end
                end
                ONE: begin
                    in_ready_q <= !(push && !pop);
                    if (push && pop) begin
                        buf_q[0] <= entry_d;
                    end else if (push) begin
                        buf_q[1] <= entry_d;
                        state_q  <= FULL;
                    end else if (pop) begin
                        state_q  <= EMPTY;
                    end
                end
                FULL: begin
                    in_ready_q <= pop;
                    if (pop) begin
                        buf_q[0] <= buf_q[1];
                        state_q  <= ONE;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // An empty stage presents an all-zero bubble to the ALU.
    assign head            = out_valid ? buf_q[0] : '0;
    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid;
    assign bus.ALUop_o     = head.alu_op;
    assign bus.operand_A_o = head.op_a;
    assign bus.operand_B_o = head.op_b;
    assign bus.rd_addr_o   = head.rd;
    assign bus.pc_o        = head.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, PC+4 wrap, backpressure,
// flush, reset and (when ID_EX_FORWARDING_EN is defined) bypass.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    int          n_run;
    int          n_fail;

    id_ex_stage_if bus ();

    id_ex_stage #(.DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .fwd_valid_i (fwd_valid),
        .fwd_rd_i    (fwd_rd),
        .fwd_data_i  (fwd_data),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic [4:0] r1a,
                         input logic [4:0] r2a, input logic [4:0] rd,
                         input logic [1:0] sa, input logic sb);
        bus.in_valid_i = 1'b1;
        bus.ALUop_i    = op;
        bus.pc_i       = pc;
        bus.rs1_data_i = r1;
        bus.rs2_data_i = r2;
        bus.imm_i      = imm;
        bus.rs1_addr_i = r1a;
        bus.rs2_addr_i = r2a;
        bus.rd_addr_i  = rd;
        bus.sel_a_i    = sa;
        bus.sel_b_i    = sb;
    endtask

    task automatic fill_full();
        bus.out_ready_i = 1'b0;
        drive(ALU_ADD, 32'h10, 32'hA1, 0, 0, 0, 0, 5'd1, SEL_A_RS1, 1'b0);
        tick();
        drive(ALU_SUB, 32'h14, 32'hB2, 0, 0, 0, 0, 5'd2, SEL_A_RS1, 1'b0);
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    logic [1:0]  s_sa  [3];
    logic        s_sb  [3];
    logic [31:0] s_pc  [3];
    logic [31:0] s_r1  [3];
    logic [31:0] s_r2  [3];
    logic [31:0] s_imm [3];
    logic [31:0] s_ea  [3];
    logic [31:0] s_eb  [3];

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst = 1'b1; flush = 1'b0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
        bus.out_ready_i = 1'b0;
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        bus.in_valid_i = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready_o}, 32'd0);
        check("rst_opA", bus.operand_A_o, 32'd0);
        rst = 1'b0;
        tick();
        check("rel_ready", {31'd0, bus.in_ready_o}, 32'd1);
        check("rel_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("rel_pc", bus.pc_o, 32'd0);

        // ADDI x1, x?, 7 with rs1 value 5
        bus.out_ready_i = 1'b1;
        drive(ALU_ADD, 32'h40, 32'd5, 32'h99, 32'd7, 5'd4, 5'd6, 5'd1,
              SEL_A_RS1, SEL_B_IMM);
        tick();
        bus.in_valid_i = 1'b0;
        check("addi_valid", {31'd0, bus.out_valid_o}, 32'd1);
        check("addi_opA", bus.operand_A_o, 32'd5);
        check("addi_opB", bus.operand_B_o, 32'd7);
        check("addi_op", {26'd0, bus.ALUop_o}, 32'd1);
        check("addi_rd", {27'd0, bus.rd_addr_o}, 32'd1);
        check("addi_pc", bus.pc_o, 32'h40);
        tick();
        check("addi_drain", {31'd0, bus.out_valid_o}, 32'd0);
        check("bubble_opA", bus.operand_A_o, 32'd0);

        // JAL link value and wraparound
        drive(ALU_ADD, 32'h100, 32'h0, 0, 32'h4, 0, 0, 5'd1, SEL_A_PC4, 1'b1);
        tick();
        check("jal_opA", bus.operand_A_o, 32'h104);
        drive(ALU_ADD, 32'hFFFF_FFFC, 32'h0, 0, 32'h4, 0, 0, 5'd1,
              SEL_A_PC4, 1'b1);
        tick();
        check("jal_wrap", bus.operand_A_o, 32'h0);
        check("jal_wrap_pc", bus.pc_o, 32'hFFFF_FFFC);

        // streaming selects, one in / one out per cycle
        s_sa[0] = SEL_A_PC;  s_sb[0] = SEL_B_RS2; s_pc[0] = 32'h200;
        s_r1[0] = 32'h1;     s_r2[0] = 32'h33;    s_imm[0] = 32'h77;
        s_ea[0] = 32'h200;   s_eb[0] = 32'h33;
        s_sa[1] = SEL_A_RSV; s_sb[1] = SEL_B_IMM; s_pc[1] = 32'h300;
        s_r1[1] = 32'hDEAD;  s_r2[1] = 32'h44;    s_imm[1] = 32'hFFFF_FFF0;
        s_ea[1] = 32'hDEAD;  s_eb[1] = 32'hFFFF_FFF0;
        s_sa[2] = SEL_A_RS1; s_sb[2] = SEL_B_RS2; s_pc[2] = 32'h400;
        s_r1[2] = 32'h1234;  s_r2[2] = 32'h5678;  s_imm[2] = 32'h9;
        s_ea[2] = 32'h1234;  s_eb[2] = 32'h5678;
        for (int i = 0; i < 3; i++) begin
            drive(ALU_XOR, s_pc[i], s_r1[i], s_r2[i], s_imm[i], 0, 0,
                  5'(i + 8), s_sa[i], s_sb[i]);
            tick();
            check($sformatf("stream%0d_A", i), bus.operand_A_o, s_ea[i]);
            check($sformatf("stream%0d_B", i), bus.operand_B_o, s_eb[i]);
            check($sformatf("stream%0d_rd", i), {27'd0, bus.rd_addr_o},
                  32'(i + 8));
        end
        bus.in_valid_i = 1'b0;
        tick();
        check("stream_drain", {31'd0, bus.out_valid_o}, 32'd0);

        // backpressure: A, B accepted, C held until space frees
        bus.out_ready_i = 1'b0;
        drive(ALU_ADD, 32'h10, 32'hA, 0, 0, 0, 0, 5'd1, SEL_A_RS1, 1'b0);
        tick();
        check("bp_ready1", {31'd0, bus.in_ready_o}, 32'd1);
        drive(ALU_ADD, 32'h14, 32'hB, 0, 0, 0, 0, 5'd2, SEL_A_RS1, 1'b0);
        tick();
        check("bp_ready2", {31'd0, bus.in_ready_o}, 32'd0);
        drive(ALU_ADD, 32'h18, 32'hC, 0, 0, 0, 0, 5'd3, SEL_A_RS1, 1'b0);
        tick();
        check("bp_hold_A", bus.operand_A_o, 32'hA);
        check("bp_hold_v", {31'd0, bus.out_valid_o}, 32'd1);
        bus.out_ready_i = 1'b1;
        tick();
        check("bp_head_B", bus.operand_A_o, 32'hB);
        check("bp_ready3", {31'd0, bus.in_ready_o}, 32'd1);
        tick();
        bus.in_valid_i = 1'b0;
        check("bp_head_C", bus.operand_A_o, 32'hC);
        check("bp_rd_C", {27'd0, bus.rd_addr_o}, 32'd3);
        tick();
        check("bp_empty", {31'd0, bus.out_valid_o}, 32'd0);

        // flush in FULL with a simultaneous push and pop
        fill_full();
        check("fl_full", {31'd0, bus.in_ready_o}, 32'd0);
        flush = 1'b1;
        bus.out_ready_i = 1'b1;
        drive(ALU_OR, 32'h50, 32'hD, 0, 0, 0, 0, 5'd7, SEL_A_RS1, 1'b0);
        tick();
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        check("fl_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("fl_opA", bus.operand_A_o, 32'd0);
        check("fl_op", {26'd0, bus.ALUop_o}, 32'd0);
        check("fl_pc", bus.pc_o, 32'd0);
        check("fl_ready", {31'd0, bus.in_ready_o}, 32'd1);

        // flush in ONE with a push: the push is discarded too
        bus.out_ready_i = 1'b0;
        drive(ALU_ADD, 32'h60, 32'hE, 0, 0, 0, 0, 5'd1, SEL_A_RS1, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        check("fl1_valid", {31'd0, bus.out_valid_o}, 32'd0);

        // reset while FULL
        fill_full();
        check("rf_valid0", {31'd0, bus.out_valid_o}, 32'd1);
        rst = 1'b1;
        tick();
        check("rf_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("rf_opA", bus.operand_A_o, 32'd0);
        check("rf_ready", {31'd0, bus.in_ready_o}, 32'd0);
        rst = 1'b0;
        tick();
        check("rf_rel_ready", {31'd0, bus.in_ready_o}, 32'd1);
        check("rf_rel_valid", {31'd0, bus.out_valid_o}, 32'd0);

        // writeback bypass
        bus.out_ready_i = 1'b1;
        fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_data = 32'hAA;
        drive(ALU_ADD, 32'h0, 32'h11, 32'h22, 0, 5'd3, 5'd3, 5'd9,
              SEL_A_RS1, SEL_B_RS2);
        tick();
`ifdef ID_EX_FORWARDING_EN
        check("fwd_A", bus.operand_A_o, 32'hAA);
        check("fwd_B", bus.operand_B_o, 32'hAA);
`else
        check("nofwd_A", bus.operand_A_o, 32'h11);
        check("nofwd_B", bus.operand_B_o, 32'h22);
`endif
        fwd_rd = 5'd0;
        drive(ALU_ADD, 32'h0, 32'h33, 32'h44, 0, 5'd0, 5'd0, 5'd9,
              SEL_A_RS1, SEL_B_RS2);
        tick();
        check("fwd_x0_A", bus.operand_A_o, 32'h33);
        check("fwd_x0_B", bus.operand_B_o, 32'h44);
        bus.in_valid_i = 1'b0;
        fwd_valid = 1'b0;
        tick();
        check("end_empty", {31'd0, bus.out_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DEPTH, 2, skid-buffer entries; only value 2 supported.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 in_valid_i / in_ready_o  in/out  1/1  decode-side handshake; transfer when both high.
REQ-005 ALUop_i  in  6  decoded ALU opcode (ALU encoding, 6'b000_000 = no-op, result 0).
REQ-006 pc_i, rs1_data_i, rs2_data_i, imm_i  in  32 each  PC, register-file reads, sign-extended immediate.
REQ-007 rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  source/destination register indices.
REQ-008 sel_a_i  in  2  operand A select: 00 rs1, 01 PC, 10 PC+4, 11 reserved (treated as 00).
REQ-009 sel_b_i  in  1  operand B select: 0 rs2, 1 imm.
REQ-010 flush_i  in  1  discard all buffered entries (branch/jump redirect).
REQ-011 fwd_valid_i, fwd_rd_i, fwd_data_i  in  1/5/32  writeback bypass (FORWARDING_EN only).
REQ-012 out_valid_o / out_ready_i  out/in  1/1  execute-side handshake.
REQ-013 ALUop_o  out  6; operand_A_o, operand_B_o  out  32 each  drive ALU inputs directly.
REQ-014 rd_addr_o  out  5; pc_o  out  32  carried alongside for writeback/branch target.

Function
REQ-015 Operand selection SHALL occur at capture; stored entry holds final ALUop, operand A, operand B, rd, pc.
REQ-016 PC+4 SHALL be computed modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-017 FSM states EMPTY, ONE, FULL; count of valid entries 0/1/2.
REQ-018 in_ready_o SHALL be registered and equal (state != FULL); no combinational path from out_ready_i.
REQ-019 Output SHALL come from head entry; out_valid_o = (state != EMPTY); latency input-to-output one cycle.
REQ-020 When out_valid_o low, ALUop_o, operand_A_o, operand_B_o, rd_addr_o, pc_o SHALL be 0 (ALU bubble yields 0).
REQ-021 EMPTY: push -> ONE. ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE, new entry becomes head next cycle.
REQ-022 FULL: pop -> ONE (second entry to head); push not accepted (in_ready_o low).
REQ-023 Outputs SHALL hold stable while out_valid_o high and out_ready_i low.
REQ-024 Order SHALL be strictly FIFO; no entry dropped or duplicated.
REQ-025 flush_i high SHALL force EMPTY next cycle, overriding simultaneous push and pop; in_ready_o high next cycle.

Reset
REQ-026 rst_i high SHALL force EMPTY, out_valid_o 0, in_ready_o 0 during reset, in_ready_o 1 first cycle after release.
REQ-027 Reset SHALL take priority over flush_i, push, pop; mid-operation reset discards all entries.
REQ-028 All data outputs 0 while in reset and after release until first push.

Configuration
REQ-029 Macro ID_EX_FORWARDING_EN defined: at capture, if fwd_valid_i and fwd_rd_i != 0 and fwd_rd_i == rs1_addr_i (rs2_addr_i), fwd_data_i SHALL replace rs1_data_i (rs2_data_i) before selection.
REQ-030 Macro undefined: fwd_* ports SHALL exist but be ignored; register data used unmodified.

Structure
REQ-031 Shared package SHALL hold ALU opcode constants, sel_a/sel_b encodings, and the packed entry struct (ALUop, opA, opB, rd, pc).
REQ-032 One sub-module, id_ex_operand_mux (combinational forwarding + selection), instantiated once at the input.

Verification
REQ-033 Push ADDI ALUop 000_001, rs1=5, imm=7, sel_b=1, out_ready=1 -> next cycle out_valid=1, opA=5, opB=7.
REQ-034 JAL sel_a=10, pc=0x100 -> operand_A_o=0x104; pc=0xFFFFFFFC -> 0x0.
REQ-035 out_ready=0, push 3 back-to-back -> 2 accepted, in_ready_o low after second, third held; release -> outputs in order, none lost.
REQ-036 FULL with flush_i and in_valid_i high same cycle -> next cycle out_valid=0, all outputs 0, in_ready_o=1.
REQ-037 rst_i asserted in FULL -> next cycle EMPTY, outputs 0; in_ready_o=1 after release.
REQ-038 ID_EX_FORWARDING_EN: fwd rd=3 data=0xAA, rs1_addr=3 -> opA=0xAA; fwd rd=0 -> rs1_data_i used.
